// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the UART receiver slice.
//   - receiver FSM state encoding (3-bit, legacy-compatible values)
//   - bit positions inside the status byte
//   - depth of the optional receive FIFO
package uart_pkg;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BRK   = 3'd4;

  localparam int unsigned RDY_BIT  = 0;
  localparam int unsigned FERR_BIT = 1;
  localparam int unsigned OVR_BIT  = 2;

  localparam int unsigned FIFO_DEPTH = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 4-entry receive FIFO used when UART_RXD_FIFO_EN is defined.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   push_i        write wdata_i (ignored when full unless popping same cycle)
//   pop_i         drop the head entry (ignored when empty)
//   wdata_i[7:0]  byte to store
//   head_o[7:0]   oldest stored entry
//   full_o        FIFO_DEPTH entries held
//   empty_o       no entries held
module uart_rx_fifo
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o
);

  logic [7:0] mem_q [FIFO_DEPTH];
  logic [1:0] wptr_q, rptr_q;
  logic [2:0] count_q, count_d;
  logic       do_push, do_pop;

  assign full_o  = (count_q == 3'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rptr_q];

  // Pop is evaluated first, so a push at full is accepted when a pop frees a slot.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + 2'd1;
      end
      if (do_pop) rptr_q <= rptr_q + 2'd1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rxd.sv
// uart_rxd: 8N1 UART receiver (LSB first, idle-high line) on the full-rate clk.
// Build option: define UART_RXD_FIFO_EN to replace the single holding
// register with a 4-entry FIFO (uart_rx_fifo). Port list is identical.
// Ports:
//   clk, reset_n  clock, asynchronous active-low reset
//   rxd           asynchronous serial input, idle high
//   rd            single-cycle pop strobe; also clears ferr/ovr
//   data[7:0]     byte at head of buffer
//   rdy           byte available
//   ferr          sticky framing error (stop bit sampled low)
//   ovr           sticky overrun (byte dropped, buffer full)
//   status[7:0]   {5'b0, ovr, ferr, rdy}
//   busy          frame in progress
module uart_rxd
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 208,
  parameter int unsigned DIV_W    = 9
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  input  logic       rd,
  output logic [7:0] data,
  output logic       rdy,
  output logic       ferr,
  output logic       ovr,
  output logic [7:0] status,
  output logic       busy
);

  localparam logic [DIV_W-1:0] CNT_HALF = DIV_W'(BAUD_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] CNT_FULL = DIV_W'(BAUD_DIV - 1);

  logic             sync1_q, rxs_q;
  logic [2:0]       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       sh_q, sh_d;
  logic             push, set_ferr, set_ovr, tick;
  logic             ferr_q, ovr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= rxd;
      rxs_q   <= sync1_q;
    end
  end

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    sh_d     = sh_q;
    push     = 1'b0;
    set_ferr = 1'b0;
    if (state_q != IDLE && state_q != BRK && !tick) cnt_d = cnt_q - 1'b1;
    case (state_q)
      IDLE: if (!rxs_q) begin
        state_d = START;
        cnt_d   = CNT_HALF;
      end
      START: if (tick) begin
        if (rxs_q) state_d = IDLE;
        else begin
          state_d = DATA;
          cnt_d   = CNT_FULL;
          idx_d   = '0;
        end
      end
      DATA: if (tick) begin
        sh_d  = {rxs_q, sh_q[7:1]};
        cnt_d = CNT_FULL;
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) state_d = STOP;
      end
      STOP: if (tick) begin
        // Frame ends mid stop bit so a following start edge is not missed.
        if (rxs_q) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          set_ferr = 1'b1;
          state_d  = BRK;
        end
      end
      BRK: if (rxs_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
    end
  end

`ifdef UART_RXD_FIFO_EN
  logic fifo_full, fifo_empty;

  uart_rx_fifo u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (rd),
    .wdata_i (sh_q),
    .head_o  (data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rdy     = !fifo_empty;
  assign set_ovr = push && fifo_full && !rd;
`else
  logic [7:0] data_q;
  logic       rdy_q;

  // A pop in the delivery cycle frees the register, so the new byte loads.
  assign set_ovr = push && rdy_q && !rd;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      rdy_q  <= 1'b0;
    end else if (push && (!rdy_q || rd)) begin
      data_q <= sh_q;
      rdy_q  <= 1'b1;
    end else if (rd) begin
      rdy_q  <= 1'b0;
    end
  end

  assign data = data_q;
  assign rdy  = rdy_q;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ferr_q <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      ferr_q <= set_ferr || (ferr_q && !rd);
      ovr_q  <= set_ovr || (ovr_q && !rd);
    end
  end

  assign ferr = ferr_q;
  assign ovr  = ovr_q;
  assign busy = (state_q != IDLE);

  always_comb begin
    status           = '0;
    status[RDY_BIT]  = rdy;
    status[FERR_BIT] = ferr_q;
    status[OVR_BIT]  = ovr_q;
  end

endmodule

// File: tb/tb_uart_rxd.sv
module tb_uart_rxd;

  localparam int unsigned BD = 16;
`ifdef UART_RXD_FIFO_EN
  localparam int unsigned DEPTH = 4;
`else
  localparam int unsigned DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       reset_n, rxd, rd;
  logic [7:0] data, status;
  logic       rdy, ferr, ovr, busy;

  int total = 0;
  int bad   = 0;

  // Reference model: bytes held by the receiver and the two sticky flags.
  logic [7:0] q[$];
  logic       m_ferr, m_ovr;

  uart_rxd #(.BAUD_DIV(BD), .DIV_W(9)) dut (
    .clk(clk), .reset_n(reset_n), .rxd(rxd), .rd(rd), .data(data),
    .rdy(rdy), .ferr(ferr), .ovr(ovr), .status(status), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] st;
    st = {5'b0, m_ovr, m_ferr, (q.size() != 0)};
    chk({tag, "_status"}, status, st);
    chk({tag, "_rdy"}, {7'b0, rdy}, {7'b0, (q.size() != 0)});
    chk({tag, "_ferr"}, {7'b0, ferr}, {7'b0, m_ferr});
    chk({tag, "_ovr"}, {7'b0, ovr}, {7'b0, m_ovr});
    chk({tag, "_busy"}, {7'b0, busy}, 8'h00);
    if (q.size() != 0) chk({tag, "_data"}, data, q[0]);
  endtask

  function automatic void m_deliver(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else m_ovr = 1'b1;
  endfunction

  function automatic void m_pop();
    if (q.size() != 0) void'(q.pop_front());
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endfunction

  // Start bit begins at the first negedge; stop level held for stop_len clocks.
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input int stop_len);
    @(negedge clk) rxd = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BD) @(negedge clk);
    end
    rxd = stop_lvl;
    repeat (stop_len) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b1, BD);
    m_deliver(b);
  endtask

  task automatic pop();
    if (q.size() != 0) chk("pop_data", data, q[0]);
    @(negedge clk) rd = 1'b1;
    @(negedge clk) rd = 1'b0;
    m_pop();
  endtask

  initial begin
    logic [7:0] b;
    reset_n = 1'b0; rxd = 1'b1; rd = 1'b0;
    q = {}; m_ferr = 1'b0; m_ovr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_data", data, 8'h00);
    check_all("reset");
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Byte 0xA5: rdy rises after the 155th edge following the start edge.
    fork
      send_good(8'hA5);
      begin
        @(negedge clk);
        repeat (154) @(negedge clk);
        chk("lat_before", {7'b0, rdy}, 8'h00);
        @(negedge clk);
        chk("lat_rdy", {7'b0, rdy}, 8'h01);
        chk("lat_data", data, 8'hA5);
      end
    join
    check_all("a5");
    pop();
    check_all("a5_pop");

    // 5-clk glitch is rejected at the start-bit sample point.
    @(negedge clk) rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    chk("glitch_busy", {7'b0, busy}, 8'h01);
    repeat (10) @(negedge clk);
    check_all("glitch");
    send_good(8'h3C);
    check_all("after_glitch");
    pop();

    // Stop bit low for 40 clk: framing error, waits in BRK until line high.
    fork
      send_frame(8'h55, 1'b0, 40);
      begin
        @(negedge clk);
        repeat (175) @(negedge clk);
        chk("brk_busy", {7'b0, busy}, 8'h01);
        chk("brk_ferr", {7'b0, ferr}, 8'h01);
        chk("brk_rdy", {7'b0, rdy}, 8'h00);
      end
    join
    m_ferr = 1'b1;
    repeat (5) @(negedge clk);
    check_all("brk_exit");
    pop();
    check_all("ferr_clr");

    // Overrun: one more byte than the buffer holds, without popping.
    for (int i = 0; i < int'(DEPTH) + 1; i++) begin
      b = (DEPTH == 1) ? 8'(8'h11 * (i + 1)) : 8'(i + 1);
      send_good(b);
    end
    check_all("ovr");
    for (int i = 0; i < int'(DEPTH); i++) pop();
    check_all("ovr_drained");

    // rd in the exact delivery cycle of 0x77 with 0x66 pending.
    send_good(8'h66);
    fork
      send_frame(8'h77, 1'b1, BD);
      begin
        @(negedge clk);
        repeat (154) @(negedge clk);
        rd = 1'b1;
        @(negedge clk) rd = 1'b0;
      end
    join
    m_pop();
    m_deliver(8'h77);
    check_all("simul");
    pop();

    // Random bytes with random pops, compared against the queue model.
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      send_good(b);
      if ($urandom_range(0, 1) == 1) pop();
      check_all("rand");
    end
    while (q.size() != 0) pop();

    // Reset in the middle of bit 4 discards the partial frame.
    b = 8'($urandom);
    @(negedge clk) rxd = 1'b0;
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      repeat (BD) @(negedge clk);
    end
    rxd = b[4];
    repeat (BD / 2) @(negedge clk);
    reset_n = 1'b0;
    rxd = 1'b1;
    #1;
    q = {}; m_ferr = 1'b0; m_ovr = 1'b0;
    chk("midrst_data", data, 8'h00);
    check_all("midrst");
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    send_good(8'h81);
    check_all("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rxd.md
Name: uart_rxd

Overview:
- Serial UART receiver: 8N1, LSB first, idle-high line. It is the receive counterpart to the floppy controller's TXD console transmitter.
- Converts the rxd pin into bytes for the 6502 workhorse CPU at I/O port IOBASE+PORT_RXD.
- Exposes a status byte for polling, merged into the PORT_CTL read path.
- Runs on the full-rate clk. It does not depend on ce.

Parameters:
- BAUD_DIV, 208, clk cycles per bit; minimum 4; 24 MHz / 115200 ≈ 208.
- DIV_W, 9, counter width; must hold BAUD_DIV-1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- rxd  in  1  asynchronous serial input, idle high
- rd  in  1  single-cycle pop strobe (CPU read of PORT_RXD qualified by ce)
- data  out  8  received byte at head of buffer
- rdy  out  1  byte available
- ferr  out  1  framing error sticky flag
- ovr  out  1  overrun sticky flag
- status  out  8  {5'b0, ovr, ferr, rdy}
- busy  out  1  frame in progress (state != IDLE)

Behaviour:
- Reset and clocking: clk; reset_n asynchronous, active-low.
- Reset values: data=0, rdy=0, ferr=0, ovr=0, busy=0, state=IDLE, both synchronizer flops=1.
- Input synchronizer: 2-flop synchronizer on rxd gives rxs. All sampling uses rxs (2-cycle input latency).
- Counter: cnt counts down; a sample point occurs when cnt==0.
- IDLE:
  - On rxs==0, go to START with cnt=BAUD_DIV/2-1.
- START:
  - At the sample point, rxs==1 is a glitch: go to IDLE with no flag change.
  - Otherwise go to DATA with cnt=BAUD_DIV-1 and bit index 0.
- DATA:
  - At each sample point, shift right: sh <= {rxs, sh[7:1]}.
  - Reload cnt=BAUD_DIV-1.
  - After bit index 7, go to STOP.
- STOP, at the sample point:
  - rxs==1: deliver sh (see Delivery below), then go to IDLE.
  - rxs==0: set ferr=1, discard the byte, go to BRK.
- BRK: remain until rxs==1, then go to IDLE. This prevents a break condition from being read as repeated frames.
- Delivery:
  - Buffer has space: in the cycle after the STOP sample, data=sh and rdy=1.
  - Buffer full: set ovr=1, drop the new byte, leave the buffered byte untouched.
- Pop:
  - rd while rdy=1: consumes the head byte and clears ferr and ovr in the same edge. In single-register mode rdy deasserts next cycle.
  - rd while rdy=0: only clears ferr and ovr; data is unchanged.
- Simultaneous rd and delivery in the same cycle: the old byte is consumed and the new byte is loaded. rdy stays 1 and no overrun is flagged.
- Reset mid-frame: immediately returns to IDLE. A partial byte is discarded.
- End of frame: a frame ends at the middle of the stop bit, so back-to-back frames with a single stop bit are received.
- Width rules: cnt is DIV_W bits. BAUD_DIV/2 uses integer truncation.

Optional Feature:
- Macro: UART_RXD_FIFO_EN.
- Defined: the holding register becomes a 4-entry FIFO (2-bit pointers, 3-bit count).
  - data shows the head entry; rdy = count!=0.
  - Overrun occurs only when delivering at count==4.
  - rd pops one entry.
  - Simultaneous push and pop at full: pop first, push accepted, ovr not set.
  - Pointers wrap modulo 4.
- Undefined: a single holding register as described in Behaviour.
- The port list is identical in both builds.

Decomposition:
- Package uart_pkg:
  - state encoding IDLE=0, START=1, DATA=2, STOP=3, BRK=4 (3-bit);
  - status bit positions RDY_BIT=0, FERR_BIT=1, OVR_BIT=2;
  - FIFO_DEPTH=4.
- Sub-module uart_rx_fifo: push/pop/full/empty with a head output, instantiated only under UART_RXD_FIFO_EN.
- The synchronizer and FSM stay inline.

Test Plan (BAUD_DIV=16):
- Send 0xA5 with a correct stop bit -> rdy rises about 154 clk after the start-bit falling edge; data=0xA5, ferr=0, ovr=0. rd pulse -> rdy=0 next cycle.
- 5-clk low glitch on idle rxd -> no state leaves START beyond the sample point; rdy, ferr and busy return to 0; a following byte 0x3C is received correctly.
- Send 0x55 with stop bit held low for 40 clk, then high -> ferr=1, rdy=0, FSM waits in BRK until rxd high. rd -> ferr=0.
- Single-register build: send 0x11 then 0x22 without rd -> data=0x11, ovr=1. With the FIFO build, send 5 bytes 0x01..0x05 -> pops return 0x01..0x04, ovr=1.
- rd asserted in the exact cycle the second byte 0x77 is delivered, with 0x66 pending -> data=0x77, rdy=1, ovr=0.
- Assert reset_n low at bit 4 of a frame, release, send 0x81 -> data=0x81, no error flags.
